// File: rtl/cache_types_pkg.sv
// Shared types for the direct-mapped instruction cache: address split,
// FSM state encoding and default geometry.
package cache_types_pkg;

    localparam int ICACHE_IDX_W = 3;
    localparam int ICACHE_TAG_W = 32 - 3 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic                    blkoff;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        FETCH1
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Valid/tag/data storage for the instruction cache: combinational read port,
// synchronous write port and a clear-all that wins over a same-cycle write.
module icache_frame_array #(
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 29 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [63:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [63:0]      wr_data,
    input  logic             wr_valid
);

    logic [SETS-1:0]  valid_reg;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [63:0]      data_mem [SETS];

    // Only the valid bits are reset; stale tag/data are harmless behind valid=0.
    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (clear) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= wr_valid;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with a zero-latency hit path and
// a two-word block fill over the iREN/iwait/iload memory handshake.
module icache_direct
    import cache_types_pkg::*;
#(
    parameter int SETS = 1 << ICACHE_IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        invalidate,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    icache_state_t    state_reg, state_next;
    logic [TAG_W-1:0] fill_tag_reg, fill_tag_next;
    logic [IDX_W-1:0] fill_idx_reg, fill_idx_next;
    logic [31:0]      buf0_reg, buf0_next;
    logic             inv_pend_reg, inv_pend_next;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             req_blk;
    logic             unused_bytoff;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [63:0]      rd_data;
    logic             wr_en;

    assign req_tag       = imemaddr[31:3+IDX_W];
    assign req_idx       = imemaddr[2+IDX_W:3];
    assign req_blk       = imemaddr[2];
    assign unused_bytoff = ^imemaddr[1:0];

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .clk      (CLK),
        .rst      (RST),
        .clear    (invalidate),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (fill_idx_reg),
        .wr_tag   (fill_tag_reg),
        .wr_data  ({iload, buf0_reg}),
        .wr_valid (~inv_pend_reg)
    );

    // A flush in progress masks the hit, so the request is treated as a miss.
    assign ihit     = imemREN && (state_reg == IDLE) && !invalidate
                      && rd_valid && (rd_tag == req_tag);
    assign imemload = ihit ? (req_blk ? rd_data[63:32] : rd_data[31:0]) : 32'h0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            fill_tag_reg <= '0;
            fill_idx_reg <= '0;
            buf0_reg     <= '0;
            inv_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fill_tag_reg <= fill_tag_next;
            fill_idx_reg <= fill_idx_next;
            buf0_reg     <= buf0_next;
            inv_pend_reg <= inv_pend_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fill_tag_next = fill_tag_reg;
        fill_idx_next = fill_idx_reg;
        buf0_next     = buf0_reg;
        inv_pend_next = inv_pend_reg;
        iREN          = 1'b0;
        iaddr         = 32'h0;
        wr_en         = 1'b0;

        // A flush landing mid-fill must keep the in-flight block from becoming valid.
        if (invalidate && (state_reg != IDLE)) begin
            inv_pend_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (imemREN && !ihit) begin
                    fill_tag_next = req_tag;
                    fill_idx_next = req_idx;
                    state_next    = FETCH0;
                end
            end
            FETCH0: begin
                iREN  = 1'b1;
                iaddr = {fill_tag_reg, fill_idx_reg, 1'b0, 2'b00};
                if (!iwait) begin
                    buf0_next  = iload;
                    state_next = FETCH1;
                end
            end
            FETCH1: begin
                iREN  = 1'b1;
                iaddr = {fill_tag_reg, fill_idx_reg, 1'b1, 2'b00};
                if (!iwait) begin
                    wr_en         = 1'b1;
                    inv_pend_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed vector table, multi-cycle
// corner sequences, and random traffic against a set-level cache model.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        invalidate;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    icache_direct dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .invalidate (invalidate),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Backing memory: fixed words for directed tests, a hash elsewhere.
    logic [31:0] mem_over [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory responder: inserts wait states per word, logs accepted addresses.
    int          wait_fixed  = 2;
    bit          wait_rand   = 1'b0;
    int          wcnt        = 0;
    int          wtarget     = -1;
    int          total_waits = 0;
    logic [31:0] fetched [$];

    always @(negedge CLK) begin
        if (iREN) begin
            if (wtarget < 0) wtarget = wait_rand ? int'($urandom_range(0, 3)) : wait_fixed;
            if (wcnt < wtarget) begin
                iwait = 1'b1;
                wcnt++;
                total_waits++;
            end else begin
                iwait = 1'b0;
                iload = mem_word(iaddr);
                fetched.push_back(iaddr);
                wcnt    = 0;
                wtarget = -1;
            end
        end else begin
            iwait   = 1'b0;
            iload   = 32'h0;
            wcnt    = 0;
            wtarget = -1;
        end
    end

    // Reference model: which block each of the 8 sets currently holds.
    bit          m_valid [8];
    logic [25:0] m_tag   [8];

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[5:3]] && (m_tag[a[5:3]] == a[31:6]);
    endfunction

    task automatic model_fill(input logic [31:0] a);
        m_valid[a[5:3]] = 1'b1;
        m_tag[a[5:3]]   = a[31:6];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic access(input logic [31:0] a, output int lat, output logic [31:0] data,
                          output int ren_n);
        bit          exp_hit;
        int          waits0;
        logic [31:0] base;
        exp_hit = model_hit(a);
        base    = {a[31:3], 3'b000};
        waits0  = total_waits;
        fetched.delete();
        lat   = 0;
        ren_n = 0;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = a;
        #1;
        while (!ihit && lat < 200) begin
            if (iREN) ren_n++;
            @(negedge CLK);
            #1;
            lat++;
        end
        data = imemload;
        check("ihit", 32'(ihit), 32'd1);
        check("imemload", data, mem_word({a[31:2], 2'b00}));
        if (exp_hit) begin
            check("hit_latency", lat, 0);
        end else begin
            check("miss_latency", lat, 3 + total_waits - waits0);
            check("fill_iren_cycles", ren_n, lat - 1);
            check("fill_words", fetched.size(), 2);
            if (fetched.size() == 2) begin
                check("fill_addr0", fetched[0], base);
                check("fill_addr1", fetched[1], base + 32'd4);
            end
        end
        model_fill(a);
        $display("access addr=0x%08h %s latency=%0d data=0x%08h", a,
                 exp_hit ? "hit" : "miss", lat, data);
    endtask

    task automatic pulse_invalidate();
        @(negedge CLK);
        imemREN    = 1'b0;
        invalidate = 1'b1;
        #1;
        check("inv_pulse_ihit", 32'(ihit), 32'd0);
        @(negedge CLK);
        invalidate = 1'b0;
        model_clear();
        $display("invalidate pulse");
    endtask

    // Invalidate while the second word of a 0x40 fill is outstanding.
    task automatic inv_during_fetch1(input int w);
        int          n;
        int          lat;
        int          rn;
        logic [31:0] d;
        pulse_invalidate();
        wait_fixed = w;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        #1;
        n = 0;
        while (!(iREN && iaddr == 32'h44) && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("inv_reach_fetch1", iaddr, 32'h44);
        invalidate = 1'b1;
        imemREN    = 1'b0;
        @(negedge CLK);
        invalidate = 1'b0;
        #1;
        n = 0;
        while (iREN && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("inv_fill_done_iren", 32'(iREN), 32'd0);
        model_clear();
        $display("invalidate during FETCH1 (wait=%0d)", w);
        access(32'h40, lat, d, rn);
        check("inv_refill_is_miss", 32'(lat > 0), 32'd1);
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic        hit;
        logic [31:0] data;
        logic [7:0]  ren;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          lat;
        int          rn;
        int          n;
        logic [31:0] d;
        logic [31:0] a;

        RST        = 1'b1;
        imemREN    = 1'b0;
        imemaddr   = 32'h0;
        invalidate = 1'b0;
        iwait      = 1'b0;
        iload      = 32'h0;
        mem_over[32'h40] = 32'hAAAA_0001;
        mem_over[32'h44] = 32'hAAAA_0002;
        mem_over[32'h80] = 32'hBBBB_0001;
        mem_over[32'h84] = 32'hBBBB_0002;

        // With 2 wait cycles per word, every miss holds iREN for 6 cycles.
        vecs[0] = '{32'h40, 1'b0, 32'hAAAA_0001, 8'd6};
        vecs[1] = '{32'h44, 1'b1, 32'hAAAA_0002, 8'd0};
        vecs[2] = '{32'h80, 1'b0, 32'hBBBB_0001, 8'd6};
        vecs[3] = '{32'h84, 1'b1, 32'hBBBB_0002, 8'd0};
        vecs[4] = '{32'h40, 1'b0, 32'hAAAA_0001, 8'd6};
        vecs[5] = '{32'h84, 1'b0, 32'hBBBB_0002, 8'd6};

        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        #1;
        check("reset_ihit", 32'(ihit), 32'd0);
        check("reset_imemload", imemload, 32'h0);
        check("reset_iREN", 32'(iREN), 32'd0);
        check("reset_iaddr", iaddr, 32'h0);
        @(negedge CLK);
        RST     = 1'b0;
        imemREN = 1'b0;
        model_clear();

        wait_fixed = 2;
        for (int i = 0; i < 6; i++) begin
            access(vecs[i].addr, lat, d, rn);
            check("vec_hit", 32'(lat == 0), 32'(vecs[i].hit));
            check("vec_data", d, vecs[i].data);
            check("vec_iren_cycles", rn, 32'(vecs[i].ren));
        end

        // Redirect during FETCH0: the 0x100 fill completes, then 0x200 misses.
        wait_fixed = 1;
        fetched.delete();
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h100;
        #1;
        check("redir_first_miss", 32'(ihit), 32'd0);
        @(negedge CLK);
        imemaddr = 32'h200;
        #1;
        check("redir_fetch0_iREN", 32'(iREN), 32'd1);
        check("redir_fetch0_iaddr", iaddr, 32'h100);
        check("redir_fetch0_ihit", 32'(ihit), 32'd0);
        n = 0;
        while (!ihit && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("redir_ihit", 32'(ihit), 32'd1);
        check("redir_data", imemload, mem_word(32'h200));
        check("redir_words", fetched.size(), 4);
        if (fetched.size() == 4) begin
            check("redir_addr0", fetched[0], 32'h100);
            check("redir_addr1", fetched[1], 32'h104);
            check("redir_addr2", fetched[2], 32'h200);
            check("redir_addr3", fetched[3], 32'h204);
        end
        model_fill(32'h100);
        model_fill(32'h200);
        $display("redirect 0x100 -> 0x200 done");
        // 0x100 and 0x200 share set 0 with 8 sets, so 0x100 was evicted.
        access(32'h100, lat, d, rn);
        check("redir_0x100_evicted", 32'(lat > 0), 32'd1);

        inv_during_fetch1(2);
        inv_during_fetch1(0);

        // Invalidate in IDLE after warm fills.
        wait_fixed = 1;
        access(32'h0, lat, d, rn);
        access(32'h8, lat, d, rn);
        access(32'h10, lat, d, rn);
        access(32'h0, lat, d, rn);
        check("warm_hit_0x0", 32'(lat), 32'd0);
        @(negedge CLK);
        imemREN    = 1'b1;
        imemaddr   = 32'h0;
        invalidate = 1'b1;
        #1;
        check("inv_idle_ihit", 32'(ihit), 32'd0);
        @(negedge CLK);
        invalidate = 1'b0;
        imemREN    = 1'b0;
        #1;
        // The masked hit starts a refill of 0x0 that is not affected by the flush.
        n = 0;
        while (iREN && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("inv_idle_refill_done", 32'(iREN), 32'd0);
        model_clear();
        model_fill(32'h0);
        $display("invalidate in IDLE");
        access(32'h8, lat, d, rn);
        check("post_inv_0x8_miss", 32'(lat > 0), 32'd1);
        access(32'h10, lat, d, rn);
        check("post_inv_0x10_miss", 32'(lat > 0), 32'd1);
        access(32'h0, lat, d, rn);
        check("post_inv_0x0_hit", 32'(lat), 32'd0);

        // Reset during FETCH0.
        access(32'h48, lat, d, rn);
        @(negedge CLK);
        imemaddr = 32'h300;
        @(negedge CLK);
        #1;
        check("rst_pre_iREN", 32'(iREN), 32'd1);
        RST = 1'b1;
        #1;
        check("rst_mid_iREN", 32'(iREN), 32'd0);
        check("rst_mid_ihit", 32'(ihit), 32'd0);
        check("rst_mid_iaddr", iaddr, 32'h0);
        check("rst_mid_imemload", imemload, 32'h0);
        @(negedge CLK);
        RST     = 1'b0;
        imemREN = 1'b0;
        model_clear();
        $display("reset during FETCH0");
        access(32'h48, lat, d, rn);
        check("post_rst_0x48_miss", 32'(lat > 0), 32'd1);

        // Random traffic with random wait states.
        wait_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                pulse_invalidate();
            end else begin
                a = 32'($urandom_range(0, 127)) << 2;
                access(a, lat, d, rn);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
